sdram_cmd_seq: RTL and testbench

//  Parametrised single-beat SDRAM controller: the successor to the fixed H57V2562 command FSM.

---
 rtl/sdram_cmd_seq_if.sv | 25 ++
 rtl/sdram_cmd_seq.sv | 278 +++++++++++++++++++++++++++
 tb/tb_sdram_cmd_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_cmd_seq_if.sv
// sdram_cmd_seq_if: request/response bus between the frame-buffer logic and
// the SDRAM command sequencer.
//   req_wr / req_rd : access request, held until ack
//   req_addr        : {bank,row,col}, stable while a request is held
//   wr_data         : write data, stable while req_wr is held
//   ack             : 1-cycle pulse, RD/WR issued for the held request
//   rd_data/rd_valid: read return, rd_valid is a 1-cycle qualifier
// master = requester, slave = sequencer.
interface sdram_cmd_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 24
);
  logic              req_wr;
  logic              req_rd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (output req_wr, req_rd, req_addr, wr_data,
                  input  ack, rd_data, rd_valid);
  modport slave  (input  req_wr, req_rd, req_addr, wr_data,
                  output ack, rd_data, rd_valid);
endinterface

// File: rtl/sdram_cmd_seq.sv
// sdram_cmd_seq: single-beat SDRAM controller. Power-up init, periodic
// auto-refresh, one read or write per request.
// Ports:
//   sclk, rst_n      clock, async active-low reset
//   init_done        high once the init sequence has finished
//   bus (slave)      request/ack/read-return handshake (sdram_cmd_seq_if)
//   sdram_*          registered SDRAM pins; sdram_dq_i is the DQ input
// Build option: define SDRAM_AUTO_PRECHARGE_EN to issue RD/WR with A10=1 and
// skip the explicit PRE; otherwise an explicit PRE to the accessed bank follows.
module sdram_cmd_seq #(
  parameter int          DATA_W   = 16,
  parameter int          BA_W     = 2,
  parameter int          ROW_W    = 13,
  parameter int          COL_W    = 9,
  parameter int          T_INIT   = 13333,
  parameter int          T_RP     = 3,
  parameter int          T_RC     = 9,
  parameter int          T_RCD    = 3,
  parameter int          T_MRD    = 2,
  parameter int          T_WR     = 2,
  parameter int          CAS_LAT  = 2,
  parameter int          T_REFI   = 930,
  parameter logic [12:0] MODE_REG = 13'h020
) (
  input  logic                sclk,
  input  logic                rst_n,
  output logic                init_done,
  sdram_cmd_seq_if.slave      bus,
  output logic                sdram_cke,
  output logic                sdram_cs_n,
  output logic                sdram_ras_n,
  output logic                sdram_cas_n,
  output logic                sdram_we_n,
  output logic [BA_W-1:0]     sdram_ba,
  output logic [ROW_W-1:0]    sdram_addr,
  output logic [DATA_W-1:0]   sdram_dq_o,
  output logic                sdram_dq_oe,
  input  logic [DATA_W-1:0]   sdram_dq_i,
  output logic [DATA_W/8-1:0] sdram_dqm
);
  localparam int ADDR_W = BA_W + ROW_W + COL_W;
  localparam int TMR_W  = $clog2(T_INIT + T_RC + T_WR + T_RP + CAS_LAT + 2);
  localparam int REF_W  = $clog2(T_REFI + 1);

`ifdef SDRAM_AUTO_PRECHARGE_EN
  localparam logic AP_EN = 1'b1;
`else
  localparam logic AP_EN = 1'b0;
`endif

  // Recovery after the explicit PRE is stretched so ACT-to-ACT never drops
  // below T_RC.
  localparam int D_RP_WR = (T_RC - T_RCD - T_WR > T_RP) ? T_RC - T_RCD - T_WR : T_RP;
  localparam int D_RP_RD = (T_RC - T_RCD - CAS_LAT > T_RP) ? T_RC - T_RCD - CAS_LAT : T_RP;
  // Auto-precharge: RD/WR straight to recovery, same T_RC floor.
  localparam int D_AP_WR = (T_RC - T_RCD > T_WR + T_RP) ? T_RC - T_RCD : T_WR + T_RP;
  localparam int D_AP_RD = (T_RC - T_RCD > CAS_LAT + T_RP) ? T_RC - T_RCD : CAS_LAT + T_RP;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  // Each state waits for the timer to expire and then issues its command.
  // INIT_WAIT issues the init PRE, INIT_FIN just waits out T_MRD.
  typedef enum logic [3:0] {
    INIT_WAIT, INIT_AR1, INIT_AR2, INIT_LMR, INIT_FIN,
    IDLE, ACT_WAIT, PRE_WAIT, RECOV
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [3:0]         cmd_q, cmd_nxt;
  logic [BA_W-1:0]    ba_nxt;
  logic [ROW_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]  dq_o_nxt;
  logic               dq_oe_nxt;
  logic               ack_q, ack_nxt;
  logic               rd_issue, ref_clr, acc_load, done_set;
  logic               acc_wr;
  logic [BA_W-1:0]    acc_ba;
  logic [COL_W-1:0]   acc_col;
  logic [REF_W-1:0]   ref_cnt;
  logic               ref_pend, ref_wrap;
  logic [CAS_LAT:0]   vld_pipe;
  logic [DATA_W-1:0]  dq_cap, rd_data_q;
  logic               rd_valid_q;

  logic [BA_W-1:0]    req_ba;
  logic [ROW_W-1:0]   req_row;
  logic [COL_W-1:0]   req_col;

  assign req_ba  = bus.req_addr[ADDR_W-1 -: BA_W];
  assign req_row = bus.req_addr[COL_W +: ROW_W];
  assign req_col = bus.req_addr[COL_W-1:0];

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_dqm    = '0;
  assign bus.ack      = ack_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

  // Timer load for "next command N cycles after this one".
  function automatic logic [TMR_W-1:0] dly(input int n);
    return TMR_W'(n - 1);
  endfunction

  always_comb begin
    logic expired, serve;
    state_nxt = state;
    timer_nxt = timer;
    cmd_nxt   = CMD_NOP;
    ba_nxt    = sdram_ba;
    addr_nxt  = sdram_addr;
    dq_o_nxt  = '0;
    dq_oe_nxt = 1'b0;
    ack_nxt   = 1'b0;
    rd_issue  = 1'b0;
    ref_clr   = 1'b0;
    acc_load  = 1'b0;
    done_set  = 1'b0;
    serve     = 1'b0;
    expired   = (timer == '0);
    if (!expired) timer_nxt = timer - TMR_W'(1);

    case (state)
      INIT_WAIT: if (expired) begin
        cmd_nxt      = CMD_PRE;
        addr_nxt     = '0;
        addr_nxt[10] = 1'b1;                 // precharge all banks
        timer_nxt    = dly(T_RP);
        state_nxt    = INIT_AR1;
      end
      INIT_AR1: if (expired) begin
        cmd_nxt   = CMD_AR;
        timer_nxt = dly(T_RC);
        state_nxt = INIT_AR2;
      end
      INIT_AR2: if (expired) begin
        cmd_nxt   = CMD_AR;
        timer_nxt = dly(T_RC);
        state_nxt = INIT_LMR;
      end
      INIT_LMR: if (expired) begin
        cmd_nxt   = CMD_LMR;
        ba_nxt    = '0;
        addr_nxt  = ROW_W'(MODE_REG);
        timer_nxt = dly(T_MRD);
        state_nxt = INIT_FIN;
      end
      INIT_FIN: if (expired) begin
        state_nxt = IDLE;
        done_set  = 1'b1;
      end
      ACT_WAIT: if (expired) begin
        cmd_nxt      = acc_wr ? CMD_WR : CMD_RD;
        ba_nxt       = acc_ba;
        addr_nxt     = ROW_W'(acc_col);
        addr_nxt[10] = AP_EN;
        ack_nxt      = 1'b1;
        if (acc_wr) begin
          dq_oe_nxt = 1'b1;
          dq_o_nxt  = bus.wr_data;
        end else begin
          rd_issue  = 1'b1;
        end
        if (AP_EN) begin
          timer_nxt = acc_wr ? dly(D_AP_WR) : dly(D_AP_RD);
          state_nxt = RECOV;
        end else begin
          timer_nxt = acc_wr ? dly(T_WR) : dly(CAS_LAT);
          state_nxt = PRE_WAIT;
        end
      end
      PRE_WAIT: if (expired) begin
        cmd_nxt   = CMD_PRE;
        ba_nxt    = acc_ba;
        addr_nxt  = '0;                      // A10=0: this bank only
        timer_nxt = acc_wr ? dly(D_RP_WR) : dly(D_RP_RD);
        state_nxt = RECOV;
      end
      // Recovery expiry serves the next job in the same cycle, so the
      // command spacing stays exact.
      RECOV: if (expired) begin
        state_nxt = IDLE;
        serve     = 1'b1;
      end
      IDLE:    serve = 1'b1;
      default: state_nxt = INIT_WAIT;
    endcase

    // Refresh wins over a waiting request; an access already under way
    // never reaches here until it has finished.
    if (serve) begin
      if (ref_pend) begin
        cmd_nxt   = CMD_AR;
        ref_clr   = 1'b1;
        timer_nxt = dly(T_RC);
        state_nxt = RECOV;
      end else if (init_done && (bus.req_wr || bus.req_rd)) begin
        cmd_nxt   = CMD_ACT;
        ba_nxt    = req_ba;
        addr_nxt  = req_row;
        acc_load  = 1'b1;
        timer_nxt = dly(T_RCD);
        state_nxt = ACT_WAIT;
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT_WAIT;
      timer       <= TMR_W'(T_INIT);
      cmd_q       <= CMD_NOP;
      sdram_cke   <= 1'b0;
      sdram_ba    <= '0;
      sdram_addr  <= '0;
      sdram_dq_o  <= '0;
      sdram_dq_oe <= 1'b0;
      ack_q       <= 1'b0;
      init_done   <= 1'b0;
      acc_wr      <= 1'b0;
      acc_ba      <= '0;
      acc_col     <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      cmd_q       <= cmd_nxt;
      sdram_cke   <= 1'b1;
      sdram_ba    <= ba_nxt;
      sdram_addr  <= addr_nxt;
      sdram_dq_o  <= dq_o_nxt;
      sdram_dq_oe <= dq_oe_nxt;
      ack_q       <= ack_nxt;
      if (done_set) init_done <= 1'b1;
      if (acc_load) begin
        acc_wr  <= bus.req_wr;              // write first when both are up
        acc_ba  <= req_ba;
        acc_col <= req_col;
      end
    end
  end

  // Refresh interval counter, free-running once init is done.
  assign ref_wrap = init_done && (ref_cnt == REF_W'(T_REFI - 1));

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
    end else begin
      if (!init_done || ref_wrap) ref_cnt <= '0;
      else                        ref_cnt <= ref_cnt + REF_W'(1);
      ref_pend <= ref_wrap || (ref_pend && !ref_clr);
    end
  end

  // Read return: vld_pipe[k] is set k cycles after RD is on the pins.
  // DQ is captured at CAS_LAT, presented one cycle later.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      dq_cap     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      vld_pipe   <= {vld_pipe[CAS_LAT-1:0], rd_issue};
      if (vld_pipe[CAS_LAT-1]) dq_cap <= sdram_dq_i;
      rd_valid_q <= vld_pipe[CAS_LAT];
      if (vld_pipe[CAS_LAT]) rd_data_q <= dq_cap;
    end
  end
endmodule

// File: tb/tb_sdram_cmd_seq.sv
module tb_sdram_cmd_seq;
  localparam int DATA_W = 16, BA_W = 2, ROW_W = 13, COL_W = 9, AW = 24;
  localparam int T_INIT = 20, T_RP = 3, T_RC = 9, T_RCD = 3, T_MRD = 2;
  localparam int T_WR = 2, CAS_LAT = 2, T_REFI = 150;
  localparam logic [12:0] MODE = 13'h020;
`ifdef SDRAM_AUTO_PRECHARGE_EN
  localparam logic AP = 1'b1;
`else
  localparam logic AP = 1'b0;
`endif
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101;
  localparam logic [3:0] C_WR = 4'b0100, C_PRE = 4'b0010, C_AR = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 sclk = ~sclk;

  logic              init_done, cke, cs_n, ras_n, cas_n, we_n, dq_oe;
  logic [BA_W-1:0]   ba;
  logic [ROW_W-1:0]  addr;
  logic [DATA_W-1:0] dq_o, dq_i;
  logic [1:0]        dqm;

  sdram_cmd_seq_if #(.DATA_W(DATA_W), .ADDR_W(AW)) bus ();

  sdram_cmd_seq #(.T_INIT(T_INIT), .T_REFI(T_REFI)) dut (
    .sclk(sclk), .rst_n(rst_n), .init_done(init_done), .bus(bus),
    .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n),
    .sdram_cas_n(cas_n), .sdram_we_n(we_n), .sdram_ba(ba),
    .sdram_addr(addr), .sdram_dq_o(dq_o), .sdram_dq_oe(dq_oe),
    .sdram_dq_i(dq_i), .sdram_dqm(dqm)
  );

  typedef struct {
    logic        wr;
    logic [23:0] a;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int cyc_n = 0, act_cyc = 0, rw_cyc = 0, rv_cyc = 0, last_ar_cyc = -1;
  int ack_cnt = 0, wr_cnt = 0, oe_bad = 0, rd_cnt = -1, done_cyc = 0;
  logic [3:0]  cmd;
  logic [1:0]  act_ba;
  logic [12:0] act_row;
  logic [12:0] open_row [4];
  logic [15:0] mem [int];
  logic [15:0] rd_pend, rv_data;
  logic        rv_flag = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // One clock: sample pins at negedge, run the SDRAM memory model.
  task automatic cyc();
    int key;
    @(negedge sclk);
    cyc_n++;
    cmd = {cs_n, ras_n, cas_n, we_n};
    if (rd_cnt == 0) begin
      dq_i = rd_pend; rd_cnt = -1;
    end else begin
      dq_i = 16'h5A5A;
      if (rd_cnt > 0) rd_cnt--;
    end
    key = int'({ba, open_row[ba], addr[COL_W-1:0]});
    case (cmd)
      C_ACT: begin open_row[ba] = addr; act_cyc = cyc_n; act_ba = ba; act_row = addr; end
      C_WR:  begin mem[key] = dq_o; wr_cnt++; rw_cyc = cyc_n; end
      C_RD:  begin rd_pend = mem.exists(key) ? mem[key] : 16'h0; rd_cnt = CAS_LAT - 2; rw_cyc = cyc_n; end
      C_AR:  last_ar_cyc = cyc_n;
      default: ;
    endcase
    if (dq_oe && cmd != C_WR) oe_bad++;
    if (bus.ack) ack_cnt++;
    if (bus.rd_valid) begin rv_flag = 1'b1; rv_cyc = cyc_n; rv_data = bus.rd_data; end
  endtask

  task automatic next_cmd(output logic [3:0] c, output int gap);
    gap = 0;
    do begin cyc(); gap++; end while (cmd == C_NOP && gap < 5000);
    c = cmd;
  endtask

  // Called right after rst_n is released at a negedge.
  task automatic check_init();
    logic [3:0] c;
    int g;
    cyc();
    chk("cke_up", cke, 1);
    chk("init_first_nop", cmd, C_NOP);
    next_cmd(c, g); chk("init_pre", c, C_PRE); chk("init_pre_gap", g, T_INIT);
    chk("init_pre_a10", addr[10], 1);
    next_cmd(c, g); chk("init_ar1", c, C_AR); chk("init_ar1_gap", g, T_RP);
    next_cmd(c, g); chk("init_ar2", c, C_AR); chk("init_ar2_gap", g, T_RC);
    next_cmd(c, g); chk("init_lmr", c, C_LMR); chk("init_lmr_gap", g, T_RC);
    chk("init_lmr_mode", addr, MODE);
    g = 0;
    do begin cyc(); g++; end while (!init_done && g < 50);
    chk("init_done_gap", g, T_MRD);
    done_cyc = cyc_n;
  endtask

  // Hold a request until ack, check ACT/RD/WR pins, then the read return.
  task automatic access(input vec_t v);
    int n;
    logic [12:0] ecol;
    ecol = 13'(v.a[8:0]);
    ecol[10] = AP;
    bus.req_wr = v.wr; bus.req_rd = !v.wr; bus.req_addr = v.a; bus.wr_data = v.wdata;
    n = 0;
    do begin cyc(); n++; end while (!bus.ack && n < 300);
    chk("ack_seen", bus.ack, 1);
    chk("rw_cmd", cmd, v.wr ? C_WR : C_RD);
    chk("rcd_gap", rw_cyc - act_cyc, T_RCD);
    chk("act_ba", act_ba, v.a[23:22]);
    chk("act_row", act_row, v.a[21:9]);
    chk("rw_ba", ba, v.a[23:22]);
    chk("rw_col", addr, ecol);
    if (v.wr) begin
      chk("wr_oe", dq_oe, 1);
      chk("wr_dq", dq_o, v.wdata);
    end
    bus.req_wr = 1'b0; bus.req_rd = 1'b0;
    if (!v.wr) begin
      rv_flag = 1'b0; n = 0;
      while (!rv_flag && n < 20) begin cyc(); n++; end
      chk("rv_seen", rv_flag, 1);
      chk("rv_gap", rv_cyc - rw_cyc, CAS_LAT + 1);
      chk("rv_data", rv_data, v.exp_rd);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    vec_t v;
    int n, a1, w, rd_act, rd_rv, ar_snap, wc0, ac0;
    tbl[0] = '{1'b1, {2'd1, 13'h0123, 9'h045}, 16'hBEEF, 16'h0};
    tbl[1] = '{1'b0, {2'd1, 13'h0123, 9'h045}, 16'h0,    16'hBEEF};
    tbl[2] = '{1'b1, {2'd3, 13'h1FFF, 9'h1FF}, 16'h1234, 16'h0};
    tbl[3] = '{1'b1, {2'd0, 13'h0000, 9'h000}, 16'hA5A5, 16'h0};
    tbl[4] = '{1'b0, {2'd3, 13'h1FFF, 9'h1FF}, 16'h0,    16'h1234};
    tbl[5] = '{1'b0, {2'd0, 13'h0000, 9'h000}, 16'h0,    16'hA5A5};
    tbl[6] = '{1'b1, {2'd2, 13'h0AAA, 9'h155}, 16'h0F0F, 16'h0};
    tbl[7] = '{1'b0, {2'd2, 13'h0AAA, 9'h155}, 16'h0,    16'h0F0F};

    bus.req_wr = 1'b0; bus.req_rd = 1'b0; bus.req_addr = '0; bus.wr_data = '0;
    dq_i = '0;
    cyc(); cyc();
    chk("rst_cke", cke, 0);
    chk("rst_cmd", {cs_n, ras_n, cas_n, we_n}, C_NOP);
    chk("rst_ba_addr", {ba, addr}, 0);
    chk("rst_dq", {dq_oe, dq_o}, 0);
    chk("rst_ack_rv", {bus.ack, bus.rd_valid, bus.rd_data}, 0);
    chk("rst_init_done", init_done, 0);
    rst_n = 1'b1;
    check_init();

    for (int i = 0; i < 8; i++) access(tbl[i]);

    // Write and read together: write first, read after write recovery.
    bus.req_wr = 1'b1; bus.req_rd = 1'b1;
    bus.req_addr = {2'd1, 13'h0123, 9'h046}; bus.wr_data = 16'hC0DE;
    n = 0;
    do begin cyc(); n++; end while (!bus.ack && n < 100);
    chk("dual_first_wr", cmd, C_WR);
    a1 = cyc_n;
    bus.req_wr = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (!bus.ack && n < 100);
    chk("dual_second_rd", cmd, C_RD);
    chk("dual_rc_ok", (cyc_n - a1) >= T_RC, 1);
    bus.req_rd = 1'b0;
    rv_flag = 1'b0; n = 0;
    while (!rv_flag && n < 20) begin cyc(); n++; end
    chk("dual_rd_data", rv_data, 16'hC0DE);

    // Refresh wrap lands in a read's T_RCD window.
    w = done_cyc;
    while (w <= cyc_n + 15) w += T_REFI;
    while (cyc_n < w - 3) cyc();
    access(tbl[7]);
    rd_act = act_cyc; rd_rv = rv_cyc; ar_snap = last_ar_cyc;
    chk("ref_not_mid_read", ar_snap < rd_act, 1);
    v = '{1'b1, {2'd2, 13'h0001, 9'h002}, 16'h7777, 16'h0};
    access(v);
    chk("ref_after_rv", last_ar_cyc > rd_rv, 1);
    chk("ref_before_act", last_ar_cyc < act_cyc, 1);

    // Reset during the T_RCD wait of a write.
    bus.req_wr = 1'b1; bus.req_addr = {2'd1, 13'h0555, 9'h011}; bus.wr_data = 16'hFFFF;
    n = 0;
    do begin cyc(); n++; end while (cmd != C_ACT && n < 100);
    cyc();
    wc0 = wr_cnt; ac0 = ack_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cke", cke, 0);
    chk("mid_rst_cmd", {cs_n, ras_n, cas_n, we_n}, C_NOP);
    chk("mid_rst_ba_addr", {ba, addr}, 0);
    chk("mid_rst_dq", {dq_oe, dq_o}, 0);
    chk("mid_rst_rd", {bus.ack, bus.rd_valid, bus.rd_data}, 0);
    chk("mid_rst_init_done", init_done, 0);
    bus.req_wr = 1'b0;
    cyc(); cyc(); cyc();
    rst_n = 1'b1;
    check_init();
    chk("no_wr_after_rst", wr_cnt, wc0);
    chk("no_ack_after_rst", ack_cnt, ac0);
    access(tbl[1]);
    chk("oe_only_in_wr", oe_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
